ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframes 11-bit frames and decodes E0/F0 prefixes into make-code strobes.
// Latency: 2 sync + FILTER_LEN filter cycles to a fall event; key_en/frame_err two cycles after the stop-bit fall.
// Backpressure: none; the PS/2 bit period is far longer than the internal latency, so no overrun path exists.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_en,
    output logic       key_ext,
    output logic       frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W = $clog2(FILTER_LEN + 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FL_W-1:0] filt_cnt;
    logic            filt_lvl, filt_prev;
    logic            fall;

    state_t          state;
    logic [3:0]      idx;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [WD_W-1:0] wd;
    logic            byte_vld;
    logic            err_int;

    logic            ext_pend, brk_pend;

    // Two-flop synchronizers; the PS/2 lines idle high, so reset to 1.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            filt_cnt  <= '0;
            filt_lvl  <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            filt_prev <= filt_lvl;
            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
                filt_lvl <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_lvl;

    // Frame FSM with watchdog; a fall event takes priority over watchdog expiry.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state    <= IDLE;
            idx      <= 4'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            wd       <= '0;
            byte_vld <= 1'b0;
            err_int  <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            err_int  <= 1'b0;
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (fall && !dat_s2) begin
                        state <= RECV;
                        idx   <= 4'd1;
                    end
                end
                RECV: begin
                    if (fall) begin
                        wd <= '0;
                        if (idx <= 4'd8) begin
                            shreg <= {dat_s2, shreg[7:1]};
                            idx   <= idx + 4'd1;
                        end else if (idx == 4'd9) begin
                            par_bit <= dat_s2;
                            idx     <= 4'd10;
                        end else begin
                            state <= IDLE;
                            idx   <= 4'd0;
                            if (dat_s2 && (^{shreg, par_bit}))
                                byte_vld <= 1'b1;
                            else
                                err_int <= 1'b1;
                        end
                    end else if (wd == WD_W'(TIMEOUT_CYCLES)) begin
                        state   <= IDLE;
                        idx     <= 4'd0;
                        wd      <= '0;
                        err_int <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= 4'd0;
                end
            endcase
        end
    end

    // Prefix layer: track E0/F0, emit make codes, drop releases, flush flags on frame errors.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            key_code  <= 8'h00;
            key_en    <= 1'b0;
            key_ext   <= 1'b0;
            frame_err <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            key_en    <= 1'b0;
            frame_err <= err_int;
            if (err_int) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_vld) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (brk_pend) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end else begin
                    key_code <= shreg;
                    key_ext  <= ext_pend;
                    key_en   <= 1'b1;
                    ext_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed frame table, corner sequences, then randomized frames vs a prefix model.
// Latency: outputs checked after each full frame has settled.
// Backpressure: none; the bench only paces the PS/2 clock.
module tb_ps2_key_decoder;

    localparam int TO   = 400;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_en;
    logic       key_ext;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .iVGA_CLK (clk),
        .iRST_n   (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_en   (key_en),
        .key_ext  (key_ext),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (key_en) en_cnt++;
        if (frame_err) err_cnt++;
        if (key_en && frame_err) both_cnt++;
    end

    typedef struct {
        logic [7:0] dat;
        bit         bad_par;
        int         exp_en;
        logic [7:0] exp_code;
        bit         exp_ext;
        int         exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first nbits of an 11-bit frame; data changes while the PS/2 clock is high.
    task automatic send_frame(input logic [7:0] d, input bit bad_p, input int nbits);
        logic [10:0] f;
        logic        p;
        p = (~(^d)) ^ bad_p;
        f = {1'b1, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit bad_p,
                             input int exp_en, input logic [7:0] exp_code,
                             input bit exp_ext, input int exp_err);
        int e0, r0;
        e0 = en_cnt;
        r0 = err_cnt;
        send_frame(d, bad_p, 11);
        check({name, ".en"}, en_cnt - e0, exp_en);
        check({name, ".err"}, err_cnt - r0, exp_err);
        check({name, ".code"}, int'(key_code), int'(exp_code));
        check({name, ".ext"}, int'(key_ext), int'(exp_ext));
    endtask

    initial begin
        logic [7:0] b;
        bit         bp;
        bit         m_ext, m_brk;
        logic [7:0] m_code;
        bit         m_kext;
        int         m_en, m_err;

        vecs[0]  = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 0};
        vecs[1]  = '{8'hE0, 1'b0, 0, 8'h1C, 1'b0, 0};
        vecs[2]  = '{8'h6B, 1'b0, 1, 8'h6B, 1'b1, 0};
        vecs[3]  = '{8'h74, 1'b0, 1, 8'h74, 1'b0, 0};
        vecs[4]  = '{8'hE0, 1'b0, 0, 8'h74, 1'b0, 0};
        vecs[5]  = '{8'hF0, 1'b0, 0, 8'h74, 1'b0, 0};
        vecs[6]  = '{8'h6B, 1'b0, 0, 8'h74, 1'b0, 0};
        vecs[7]  = '{8'h1C, 1'b0, 1, 8'h1C, 1'b0, 0};
        vecs[8]  = '{8'h1C, 1'b1, 0, 8'h1C, 1'b0, 1};
        vecs[9]  = '{8'hE0, 1'b0, 0, 8'h1C, 1'b0, 0};
        vecs[10] = '{8'h5A, 1'b1, 0, 8'h1C, 1'b0, 1};
        vecs[11] = '{8'h5A, 1'b0, 1, 8'h5A, 1'b0, 0};

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        wait_cyc(5);
        check("rst.code", int'(key_code), 0);
        check("rst.en", int'(key_en), 0);
        check("rst.ext", int'(key_ext), 0);
        check("rst.err", int'(frame_err), 0);
        rst_n = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 12; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].dat, vecs[i].bad_par,
                      vecs[i].exp_en, vecs[i].exp_code, vecs[i].exp_ext, vecs[i].exp_err);

        // Timeout: start plus four data bits, then the clock stays high past the watchdog.
        m_err = err_cnt;
        m_en  = en_cnt;
        send_frame(8'h0F, 1'b0, 5);
        wait_cyc(TO + 100);
        check("timeout.err", err_cnt - m_err, 1);
        check("timeout.en", en_cnt - m_en, 0);
        run_frame("after_to", 8'h74, 1'b0, 1, 8'h74, 1'b0, 0);

        // Short low glitch with data low must not look like a start bit.
        ps2_data = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        run_frame("after_glitch", 8'h1C, 1'b0, 1, 8'h1C, 1'b0, 0);

        // Reset mid-frame: outputs clear, no error pulse, next frame decodes.
        m_err = err_cnt;
        send_frame(8'h33, 1'b0, 6);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst.code", int'(key_code), 0);
        check("midrst.ext", int'(key_ext), 0);
        check("midrst.en", int'(key_en), 0);
        check("midrst.err", int'(frame_err), 0);
        rst_n = 1'b1;
        wait_cyc(HALF);
        check("midrst.nopulse", err_cnt - m_err, 0);
        run_frame("after_rst", 8'h74, 1'b0, 1, 8'h74, 1'b0, 0);

        // Randomized frames against a flag-level model of the prefix rules.
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_code = 8'h74;
        m_kext = 1'b0;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bp    = ($urandom_range(0, 7) == 0);
            m_en  = 0;
            m_err = 0;
            if (bp) begin
                m_err = 1;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) begin
                m_ext = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (m_brk) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else begin
                m_en   = 1;
                m_code = b;
                m_kext = m_ext;
                m_ext  = 1'b0;
            end
            run_frame($sformatf("rnd%0d_%02h_%0d", i, b, bp), b, bp, m_en, m_code, m_kext, m_err);
        end

        check("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
